// File: rtl/hex_word_entry_if.sv
// hex_word_entry_if: switch/button inputs and word handshake of the hex word entry block.
// Handshake: word_valid rises when the eighth nibble is entered and stays high
// until the edge that samples word_ack = 1; word is read in that same cycle.
// word_ack is ignored while word_valid = 0.
interface hex_word_entry_if;
    logic [3:0]  sw;
    logic        btn_enter;
    logic        btn_clear;
    logic        word_ack;
    logic [31:0] word;
    logic        word_valid;
    logic [3:0]  digit_count;
    logic        overrun;
    logic        dbg_full;     // FSM state for checkers: 1 = FULL, 0 = ENTRY

    modport master (
        output sw, btn_enter, btn_clear, word_ack,
        input  word, word_valid, digit_count, overrun, dbg_full
    );

    modport slave (
        input  sw, btn_enter, btn_clear, word_ack,
        output word, word_valid, digit_count, overrun, dbg_full
    );
endinterface

// File: rtl/hex_word_entry.sv
// hex_word_entry: debounces enter/clear pushbuttons and assembles a 32-bit word
// one hex nibble at a time from the switches, handing it off with valid/ack.
// Optional feature macro HEX_ENTRY_SYNC_EN: adds two-flop synchronizers on the
// buttons and switches (2 extra cycles of press latency).
module hex_word_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    hex_word_entry_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Button vector index: 0 = enter, 1 = clear
    logic [1:0] db_in;
    logic [3:0] sw_use;

`ifdef HEX_ENTRY_SYNC_EN
    logic [1:0] btn_meta_q;
    logic [1:0] btn_sync_q;
    logic [3:0] sw_meta_q;
    logic [3:0] sw_sync_q;

    // Two-flop synchronizers for buttons and switches
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= {bus.btn_clear, bus.btn_enter};
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign db_in  = btn_sync_q;
    assign sw_use = sw_sync_q;
`else
    assign db_in  = {bus.btn_clear, bus.btn_enter};
    assign sw_use = bus.sw;
`endif

    // ------------------------------------------------------------------
    // Debouncers: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive samples that differ from the stable level.
    // ------------------------------------------------------------------
    logic [1:0]    db_stable_q, db_stable_d;
    logic [CW-1:0] db_cnt_q [2];
    logic [CW-1:0] db_cnt_d [2];
    logic [1:0]    press;

    // Debouncer next state and press events (rising edge of the stable level)
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_stable_d[i] = db_stable_q[i];
            db_cnt_d[i]    = '0;
            press[i]       = 1'b0;
            if (db_in[i] != db_stable_q[i]) begin
                if (db_cnt_q[i] == CNT_LAST) begin
                    db_stable_d[i] = db_in[i];
                    press[i]       = db_in[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debouncer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            db_stable_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            db_stable_q <= db_stable_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    logic enter_ev;
    logic clear_ev;
    assign enter_ev = press[0];
    assign clear_ev = press[1];

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  count_q, count_d;
    logic        overrun_q, overrun_d;

    // Next-state logic; priority is clear > ack > enter
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (clear_ev) begin
            state_d   = ENTRY;
            word_d    = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    // word_ack is meaningless here and deliberately ignored
                    if (enter_ev) begin
                        word_d  = {word_q[27:0], sw_use};
                        count_d = count_q + 4'd1;
                        if (count_q == 4'd7) state_d = FULL;
                    end
                end
                FULL: begin
                    if (bus.word_ack) begin
                        state_d   = ENTRY;
                        word_d    = '0;
                        count_d   = '0;
                        overrun_d = 1'b0;
                    end else if (enter_ev) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = ENTRY;
            endcase
        end
    end

    // FSM and word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ENTRY;
            word_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.word        = word_q;
    assign bus.word_valid  = (state_q == FULL);
    assign bus.digit_count = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.dbg_full    = (state_q == FULL);

endmodule

// File: tb/tb_hex_word_entry.sv
// tb_hex_word_entry: drives press sequences into hex_word_entry and compares
// every cycle against a nibble-queue model of the entered word.
module tb_hex_word_entry;

    localparam int D = 4;
`ifdef HEX_ENTRY_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Edges after the first high sample until the press is acted on
    localparam int LAT     = D - 1 + SYNC_LAT;
    localparam int MIN_GAP = D + SYNC_LAT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_word_entry_if bus ();

    hex_word_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the nibbles entered so far, oldest first, plus the overrun flag
    logic [3:0] nib_q[$];
    bit         m_ovr;

    function automatic logic [31:0] m_word();
        logic [31:0] w = '0;
        foreach (nib_q[i]) w = (w << 4) | 32'(nib_q[i]);
        return w;
    endfunction

    function automatic void m_clear();
        nib_q.delete();
        m_ovr = 1'b0;
    endfunction

    function automatic void m_enter(input logic [3:0] nib);
        if (nib_q.size() < 8) nib_q.push_back(nib);
        else m_ovr = 1'b1;
    endfunction

    // One press action: buttons high for len cycles then low for gap cycles,
    // optional word_ack on cycle ack_tick; outputs compared after every edge.
    task automatic press(input bit en, input bit cl, input logic [3:0] nib,
                         input int len, input int gap, input int ack_tick,
                         input string tag);
        bit ev;
        bit ack;
        for (int i = 1; i <= len + gap; i++) begin
            ack           = (i == ack_tick);
            bus.btn_enter = en && (i <= len);
            bus.btn_clear = cl && (i <= len);
            bus.sw        = nib;
            bus.word_ack  = ack;
            @(posedge clk);
            ev = (len >= D) && (i == LAT + 1);
            if (ev && cl)                     m_clear();
            else if (ack && nib_q.size() == 8) m_clear();
            else if (ev && en)                m_enter(nib);
            #1;
            n_checks++;
            if (bus.word !== m_word()) begin
                n_fail++;
                $display("FAIL %s word cycle %0d: got %h expected %h", tag, i, bus.word, m_word());
            end
            n_checks++;
            if (bus.digit_count !== 4'(nib_q.size())) begin
                n_fail++;
                $display("FAIL %s digit_count cycle %0d: got %0d expected %0d", tag, i, bus.digit_count, nib_q.size());
            end
            n_checks++;
            if (bus.word_valid !== (nib_q.size() == 8)) begin
                n_fail++;
                $display("FAIL %s word_valid cycle %0d: got %b expected %b", tag, i, bus.word_valid, nib_q.size() == 8);
            end
            n_checks++;
            if (bus.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL %s overrun cycle %0d: got %b expected %b", tag, i, bus.overrun, m_ovr);
            end
        end
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.word_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.sw        = 4'h0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.word_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        n_checks++;
        if (bus.word !== 32'h0) begin
            n_fail++; $display("FAIL reset word: got %h expected 0", bus.word);
        end
        n_checks++;
        if (bus.digit_count !== 4'd0) begin
            n_fail++; $display("FAIL reset digit_count: got %0d expected 0", bus.digit_count);
        end
        n_checks++;
        if (bus.word_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset word_valid: got %b expected 0", bus.word_valid);
        end
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset overrun: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_full_word();
        for (int k = 1; k <= 8; k++)
            press(1'b1, 1'b0, 4'(k), 6, MIN_GAP, 0, "full_word");
        n_checks++;
        if (bus.word !== 32'h12345678) begin
            n_fail++; $display("FAIL full_word value: got %h expected 12345678", bus.word);
        end
        press(1'b0, 1'b0, 4'h0, 0, 1, 1, "full_word_ack");
        n_checks++;
        if (bus.word !== 32'h0 || bus.word_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_word after ack: got %h/%b expected 0/0", bus.word, bus.word_valid);
        end
    endtask

    task automatic test_glitch();
        press(1'b1, 1'b0, 4'hA, D - 1, MIN_GAP, 0, "glitch_short");
        press(1'b1, 1'b0, 4'hA, D, MIN_GAP, 0, "glitch_min_press");
        n_checks++;
        if (bus.word !== 32'h0000000A) begin
            n_fail++; $display("FAIL glitch word: got %h expected 0000000a", bus.word);
        end
    endtask

    task automatic test_hold();
        press(1'b0, 1'b1, 4'h0, D, MIN_GAP, 0, "hold_clear");
        press(1'b1, 1'b0, 4'h5, 100, MIN_GAP, 0, "hold_100");
        n_checks++;
        if (bus.digit_count !== 4'd1) begin
            n_fail++; $display("FAIL hold digit_count: got %0d expected 1", bus.digit_count);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] pat = 32'hDEADBEEF;
        press(1'b0, 1'b1, 4'h0, D, MIN_GAP, 0, "ovr_clear");
        for (int k = 7; k >= 0; k--)
            press(1'b1, 1'b0, pat[k*4 +: 4], D + 1, MIN_GAP, 0, "ovr_fill");
        press(1'b1, 1'b0, 4'h3, D, MIN_GAP, 0, "ovr_extra");
        n_checks++;
        if (bus.word !== 32'hDEADBEEF || bus.overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun set: got %h/%b expected deadbeef/1", bus.word, bus.overrun);
        end
        press(1'b0, 1'b0, 4'h0, 0, 1, 1, "ovr_ack");
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun after ack: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 5; k++)
            press(1'b1, 1'b0, 4'(k + 9), D + 2, MIN_GAP, 0, "clr_fill");
        press(1'b0, 0, 4'h0, 0, 1, 1, "clr_ack_in_entry");
        press(1'b0, 1'b1, 4'h0, D, MIN_GAP, 0, "clr_press");
        n_checks++;
        if (bus.word !== 32'h0 || bus.digit_count !== 4'd0) begin
            n_fail++; $display("FAIL clear: got %h/%0d expected 0/0", bus.word, bus.digit_count);
        end
        press(1'b1, 1'b0, 4'h7, D, MIN_GAP, 0, "clr_one");
        press(1'b1, 1'b1, 4'h6, D, MIN_GAP, 0, "clr_and_enter");
        n_checks++;
        if (bus.digit_count !== 4'd0) begin
            n_fail++; $display("FAIL clear+enter digit_count: got %0d expected 0", bus.digit_count);
        end
        for (int k = 0; k < 8; k++)
            press(1'b1, 1'b0, 4'(15 - k), D, MIN_GAP, 0, "ack_enter_fill");
        press(1'b1, 1'b0, 4'h1, D, MIN_GAP, LAT + 1, "ack_and_enter");
        n_checks++;
        if (bus.overrun !== 1'b0 || bus.digit_count !== 4'd0) begin
            n_fail++; $display("FAIL ack+enter: got ovr %b count %0d expected 0/0", bus.overrun, bus.digit_count);
        end
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0, 4'h2, D, MIN_GAP, 0, "rmid_fill");
        press(1'b1, 1'b0, 4'h4, D, MIN_GAP, 0, "rmid_fill");
        bus.sw        = 4'h9;
        bus.btn_enter = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        m_clear();
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.word !== 32'h0 || bus.digit_count !== 4'd0 || bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %h/%0d/%b/%b expected all 0",
                     bus.word, bus.digit_count, bus.word_valid, bus.overrun);
        end
        for (int i = 1; i <= LAT + 1; i++) begin
            @(posedge clk);
            if (i == LAT + 1) m_enter(4'h9);
            #1;
            n_checks++;
            if (bus.word !== m_word() || bus.digit_count !== 4'(nib_q.size())) begin
                n_fail++;
                $display("FAIL reset_mid restart cycle %0d: got %h/%0d expected %h/%0d",
                         i, bus.word, bus.digit_count, m_word(), nib_q.size());
            end
        end
        press(1'b0, 1'b0, 4'h9, 0, MIN_GAP, 0, "rmid_release");
    endtask

    task automatic test_random();
        int r;
        int gap;
        logic [3:0] nib;
        press(1'b0, 1'b1, 4'h0, D, MIN_GAP, 0, "rand_clear");
        for (int it = 0; it < 60; it++) begin
            r   = $urandom_range(0, 9);
            nib = 4'($urandom_range(0, 15));
            gap = $urandom_range(MIN_GAP, MIN_GAP + 3);
            case (r)
                6:       press(1'b1, 1'b0, nib, $urandom_range(1, D - 1), gap, 0, "rand_glitch");
                7:       press(1'b0, 1'b1, nib, $urandom_range(D, D + 3), gap, 0, "rand_clear");
                8:       press(1'b0, 1'b0, nib, 0, 1, 1, "rand_ack");
                9:       press(1'b1, 1'b0, nib, D, gap, $urandom_range(1, D + gap), "rand_enter_ack");
                default: press(1'b1, 1'b0, nib, $urandom_range(D, D + 4), gap, 0, "rand_enter");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_glitch();
        test_hold();
        test_overrun();
        test_clear_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
